// File: rtl/sfx_if.sv
// Game-event requests, mute control and audio/status outputs of the sound-effect sequencer.
interface sfx_if;
   logic       req_flap;
   logic       req_coin;
   logic       req_score;
   logic       req_hit;
   logic       mute;
   logic       audio;
   logic       busy;
   logic [1:0] cur_fx;
   logic       fx_done;

   modport master (
      output req_flap, req_coin, req_score, req_hit, mute,
      input  audio, busy, cur_fx, fx_done
   );

   modport slave (
      input  req_flap, req_coin, req_score, req_hit, mute,
      output audio, busy, cur_fx, fx_done
   );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: fixed-priority arbitration with preemption among
// flap/coin/score/hit, each played as one or two square-wave notes.
//
// state | meaning
// IDLE  | nothing playing, audio low
// NOTE0 | first note of cur_fx playing
// NOTE1 | second note of cur_fx playing (coin, score, hit only)
module sfx_sequencer #(
   parameter int CLK_HZ   = 100000000,
   parameter int TICK_DIV = 100000,
   parameter int HP_SHIFT = 0
) (
   input logic  clk,
   input logic  rst,
   sfx_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, NOTE0, NOTE1} state_t;

   state_t        state;
   logic [3:0]    pending;
   logic          busy_q;
   logic [1:0]    cur_q;
   logic          done_q;
   logic          phase;
   logic [18:0]   tone_cnt;
   logic [18:0]   hp_tc;
   logic [8:0]    tick_cnt;
   logic [8:0]    dur_q;
   logic [PW-1:0] presc;

   logic [3:0] req, cur_mask, cand, start_mask;
   logic [1:0] top;
   logic       tick, note_end, has_second, preempt, complete, start;

   // Terminal count of the tone counter (half-period minus one), never below zero.
   function automatic logic [18:0] hp_term(input logic [1:0] fx, input logic second);
      logic [18:0] base;
      case ({fx, second})
         3'b000, 3'b001: base = 19'd56818;
         3'b010:         base = 19'd50607;
         3'b011:         base = 19'd37908;
         3'b100:         base = 19'd47755;
         3'b101:         base = 19'd31888;
         3'b110:         base = 19'd227273;
         default:        base = 19'd454545;
      endcase
      base = base >> HP_SHIFT;
      if (base == 19'd0) base = 19'd1;
      return base - 19'd1;
   endfunction

   function automatic logic [8:0] dur_of(input logic [1:0] fx, input logic second);
      logic [8:0] d;
      case ({fx, second})
         3'b000, 3'b001: d = 9'd40;
         3'b010:         d = 9'd60;
         3'b011:         d = 9'd120;
         3'b100:         d = 9'd80;
         3'b101:         d = 9'd80;
         3'b110:         d = 9'd150;
         default:        d = 9'd250;
      endcase
      return d;
   endfunction

   function automatic logic [1:0] top_of(input logic [3:0] c);
      if (c[3])      return 2'd3;
      else if (c[2]) return 2'd2;
      else if (c[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   // Arbitration and note-end decode for the current cycle.
   always_comb begin
      req        = {bus.req_hit, bus.req_score, bus.req_coin, bus.req_flap};
      // A request for the effect already playing is dropped, not queued.
      cur_mask   = busy_q ? (4'b0001 << cur_q) : 4'b0000;
      cand       = pending | (req & ~cur_mask);
      top        = top_of(cand);
      tick       = (presc == PRESC_TC);
      note_end   = busy_q && tick && ((tick_cnt + 9'd1) == dur_q);
      has_second = (state == NOTE0) && (cur_q != 2'd0);
      preempt    = busy_q && (cand != 4'b0000) && (top > cur_q);
      complete   = note_end && !has_second && !preempt;
      start      = ((state == IDLE) && (cand != 4'b0000)) || preempt ||
                   (complete && (cand != 4'b0000));
      start_mask = start ? (4'b0001 << top) : 4'b0000;
   end

   // Sequencer FSM with tone, prescaler and tick counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pending  <= 4'b0000;
         busy_q   <= 1'b0;
         cur_q    <= 2'd0;
         done_q   <= 1'b0;
         phase    <= 1'b0;
         tone_cnt <= 19'd0;
         hp_tc    <= 19'd0;
         tick_cnt <= 9'd0;
         dur_q    <= 9'd0;
         presc    <= '0;
      end else begin
         pending <= cand & ~start_mask;
         done_q  <= complete;
         if (start) begin
            state    <= NOTE0;
            busy_q   <= 1'b1;
            cur_q    <= top;
            phase    <= 1'b1;
            hp_tc    <= hp_term(top, 1'b0);
            dur_q    <= dur_of(top, 1'b0);
            tone_cnt <= 19'd0;
            presc    <= '0;
            tick_cnt <= 9'd0;
         end else if (note_end && has_second) begin
            state    <= NOTE1;
            phase    <= 1'b1;
            hp_tc    <= hp_term(cur_q, 1'b1);
            dur_q    <= dur_of(cur_q, 1'b1);
            tone_cnt <= 19'd0;
            presc    <= '0;
            tick_cnt <= 9'd0;
         end else if (complete) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            cur_q    <= 2'd0;
            phase    <= 1'b0;
            tone_cnt <= 19'd0;
            presc    <= '0;
            tick_cnt <= 9'd0;
         end else if (busy_q) begin
            if (tone_cnt == hp_tc) begin
               tone_cnt <= 19'd0;
               phase    <= ~phase;
            end else begin
               tone_cnt <= tone_cnt + 19'd1;
            end
            if (tick) begin
               presc    <= '0;
               tick_cnt <= tick_cnt + 9'd1;
            end else begin
               presc    <= presc + PW'(1);
            end
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.cur_fx  = cur_q;
   assign bus.fx_done = done_q;

   // Mute gates only the pin, so the internal phase keeps running underneath.
   // CLK_HZ is informational; a non-positive value is treated as a dead clock.
   if (CLK_HZ > 0) begin : g_audio
      assign bus.audio = phase & ~bus.mute;
   end else begin : g_audio_off
      assign bus.audio = 1'b0;
   end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_DIV = 10 and HP_SHIFT = 10.
// Half-periods: flap 55, coin 49/37, score 46/31, hit 221/443 cycles.
// Note lengths: flap 400, coin 600/1200, score 800/800, hit 1500/2500 cycles.
module tb_sfx_sequencer;
   logic clk;
   logic rst;
   int   tests_run = 0;
   int   fails = 0;

   sfx_if bus ();

   sfx_sequencer #(.CLK_HZ(100000000), .TICK_DIV(10), .HP_SHIFT(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a one-cycle request pattern {hit, score, coin, flap}; returns one cycle later.
   task automatic pulse(input logic [3:0] m);
      {bus.req_hit, bus.req_score, bus.req_coin, bus.req_flap} = m;
      @(negedge clk);
      {bus.req_hit, bus.req_score, bus.req_coin, bus.req_flap} = 4'b0000;
   endtask

   // Samples note cycles from..to-1 against the expected square wave; the word is
   // {fx_done, audio, busy, cur_fx}. Leaves the bench at sample index 'to'.
   task automatic watch(input int hp, input int from, input int to, input logic [1:0] fx,
                        input bit muted, output int bad, output int first,
                        output logic [4:0] got_w, output logic [4:0] want_w);
      logic [4:0] got, want;
      logic       exp_a;
      bad = 0; first = -1; got_w = '0; want_w = '0;
      for (int k = from; k < to; k++) begin
         exp_a = muted ? 1'b0 : (((k / hp) % 2) == 0);
         want  = {1'b0, exp_a, 1'b1, fx};
         got   = {bus.fx_done, bus.audio, bus.busy, bus.cur_fx};
         if (got !== want) begin
            if (bad == 0) begin
               first = k; got_w = got; want_w = want;
            end
            bad++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [4:0] got;
      rst = 1'b0;
      {bus.req_hit, bus.req_score, bus.req_coin, bus.req_flap, bus.mute} = 5'b0;
      repeat (3) @(negedge clk);
      got = {bus.fx_done, bus.audio, bus.busy, bus.cur_fx};
      tests_run++;
      if (got !== 5'b00000) begin
         fails++; $display("FAIL reset_state: got %b want 00000", got);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      got = {bus.fx_done, bus.audio, bus.busy, bus.cur_fx};
      tests_run++;
      if (got !== 5'b00000) begin
         fails++; $display("FAIL idle_after_reset: got %b want 00000", got);
      end
   endtask

   task automatic test_flap();
      int bad, first; logic [4:0] g, w;
      pulse(4'b0001);
      tests_run++;
      if ({bus.audio, bus.busy, bus.cur_fx} !== 4'b1100) begin
         fails++; $display("FAIL flap_start: got %b want 1100", {bus.audio, bus.busy, bus.cur_fx});
      end
      watch(55, 0, 400, 2'd0, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL flap_wave: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b10000) begin
         fails++; $display("FAIL flap_done: got %b want 10000", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
      tests_run++;
      if (bus.fx_done !== 1'b0) begin
         fails++; $display("FAIL flap_done_width: got %b want 0", bus.fx_done);
      end
   endtask

   task automatic test_coin();
      int bad, first; logic [4:0] g, w;
      pulse(4'b0010);
      watch(49, 0, 600, 2'd1, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL coin_note0: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      watch(37, 0, 1200, 2'd1, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL coin_note1: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b10000) begin
         fails++; $display("FAIL coin_done: got %b want 10000", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int bad, first, dones; logic [4:0] g, w;
      dones = 0;
      pulse(4'b0111);
      watch(46, 0, 800, 2'd2, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL b2b_score0: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      watch(31, 0, 800, 2'd2, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL b2b_score1: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      dones += int'(bus.fx_done);
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b11101) begin
         fails++; $display("FAIL b2b_score_to_coin: got %b want 11101", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
      watch(49, 1, 600, 2'd1, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL b2b_coin0: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      watch(37, 0, 1200, 2'd1, 1'b0, bad, first, g, w);
      dones += int'(bus.fx_done);
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b11100) begin
         fails++; $display("FAIL b2b_coin_to_flap: got %b want 11100", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
      watch(55, 1, 400, 2'd0, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL b2b_flap: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      dones += int'(bus.fx_done);
      tests_run++;
      if (dones !== 3 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL b2b_done_count: got %0d dones busy=%b want 3 dones busy=0", dones, bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_preempt();
      int bad, first, busy_seen; logic [4:0] g, w;
      pulse(4'b0100);
      watch(46, 0, 100, 2'd2, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL pre_score: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      pulse(4'b1000);
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b01111) begin
         fails++; $display("FAIL pre_hit_start: got %b want 01111", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      watch(221, 0, 1500, 2'd3, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL pre_hit0: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      watch(443, 0, 2500, 2'd3, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL pre_hit1: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b10000) begin
         fails++; $display("FAIL pre_hit_done: got %b want 10000", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      busy_seen = 0;
      repeat (30) begin
         @(negedge clk);
         busy_seen += int'(bus.busy);
      end
      tests_run++;
      if (busy_seen !== 0) begin
         fails++; $display("FAIL pre_no_replay: got %0d busy cycles want 0", busy_seen);
      end
   endtask

   task automatic test_retrigger();
      int bad, first; logic [4:0] g, w;
      pulse(4'b1000);
      watch(221, 0, 300, 2'd3, 1'b0, bad, first, g, w);
      pulse(4'b1001);
      watch(221, 301, 1500, 2'd3, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL retrig_hit0: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      watch(443, 0, 2500, 2'd3, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL retrig_hit1: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b11100) begin
         fails++; $display("FAIL retrig_flap_chain: got %b want 11100", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
      watch(55, 1, 400, 2'd0, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0 || {bus.fx_done, bus.busy} !== 2'b10) begin
         fails++; $display("FAIL retrig_flap: %0d bad first k=%0d got %b want %b, end done/busy %b want 10", bad, first, g, w, {bus.fx_done, bus.busy});
      end
      @(negedge clk);
   endtask

   task automatic test_mute();
      int bad, first; logic [4:0] g, w;
      bus.mute = 1'b1;
      pulse(4'b0010);
      watch(49, 0, 600, 2'd1, 1'b1, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL mute_coin0: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      watch(37, 0, 500, 2'd1, 1'b1, bad, first, g, w);
      bus.mute = 1'b0;
      watch(37, 500, 1200, 2'd1, 1'b0, bad, first, g, w);
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL mute_release_phase: %0d bad, first k=%0d got %b want %b", bad, first, g, w);
      end
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b10000) begin
         fails++; $display("FAIL mute_done: got %b want 10000", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_note();
      int bad, first, busy_seen; logic [4:0] g, w;
      pulse(4'b1000);
      watch(221, 0, 100, 2'd3, 1'b0, bad, first, g, w);
      pulse(4'b0001);
      rst = 1'b0;
      #1;
      tests_run++;
      if ({bus.fx_done, bus.audio, bus.busy, bus.cur_fx} !== 5'b00000) begin
         fails++; $display("FAIL reset_async: got %b want 00000", {bus.fx_done, bus.audio, bus.busy, bus.cur_fx});
      end
      @(negedge clk);
      rst = 1'b1;
      busy_seen = 0;
      repeat (50) begin
         @(negedge clk);
         busy_seen += int'(bus.busy);
      end
      tests_run++;
      if (busy_seen !== 0) begin
         fails++; $display("FAIL reset_drops_pending: got %0d busy cycles want 0", busy_seen);
      end
   endtask

   initial begin
      test_reset();
      test_flap();
      test_coin();
      test_back_to_back();
      test_preempt();
      test_retrigger();
      test_mute();
      test_reset_mid_note();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
